// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the Booth multiplier sequencer slice.
//   N_DEFAULT   default operand width
//   seq_state_t sequencer FSM states (ZERO is reachable only with
//               BOOTH_SEQ_ZERO_BYPASS_EN defined)
//   run_len()   core run length: one load cycle plus n Booth iterations
package booth_pkg;

   localparam int unsigned N_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      ZERO = 2'd3
   } seq_state_t;

   function automatic int unsigned run_len(input int unsigned n);
      return n + 1;
   endfunction

endpackage

// File: rtl/booth_mul_sequencer_if.sv
// booth_mul_sequencer_if: operand-in / product-out handshake bundle.
//   in_valid/in_ready/in_m/in_q  operand pair channel (valid/ready)
//   out_valid/out_ready/out_p    signed 2N-bit product channel (valid/ready)
// Modports: master = producer/consumer side, slave = sequencer side.
interface booth_mul_sequencer_if
   import booth_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT
);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   in_m;
   logic [N-1:0]   in_q;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] out_p;

   modport master (
      output in_valid, in_m, in_q, out_ready,
      input  in_ready, out_valid, out_p
   );

   modport slave (
      input  in_valid, in_m, in_q, out_ready,
      output in_ready, out_valid, out_p
   );
endinterface

// File: rtl/booth_opnd_fifo.sv
// booth_opnd_fifo: small synchronous FIFO for operand pairs.
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  push (ignored while full)
//   rd_en, rd_data  pop (ignored while empty); rd_data shows the head
//   full, empty     occupancy flags, combinational from the count
// Pointers are log2(DEPTH) bits and wrap naturally; DEPTH must be a
// power of two, >= 2.
module booth_opnd_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: control stage around a sequential radix-2 Booth core.
// Buffers operand pairs, starts one core run per pair by pulsing mul_load,
// times the fixed N+1 cycle run and presents the captured product on a
// valid/ready output.
//   clk, rst            clock, synchronous active-high reset
//   bus (slave)         in_valid/in_ready/in_m/in_q, out_valid/out_ready/out_p
//   mul_load            core load/reset strobe (one cycle per run)
//   mul_m, mul_q        operands held for the core until the next issue
//   mul_p               core product
//   busy                FSM active or operands still queued
// Optional: BOOTH_SEQ_ZERO_BYPASS_EN skips the core when either operand is
// zero and emits a zero product through the ZERO state.
module booth_mul_sequencer
   import booth_pkg::*;
#(
   parameter int unsigned N     = N_DEFAULT,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   booth_mul_sequencer_if.slave     bus,
   output logic                     mul_load,
   output logic [N-1:0]             mul_m,
   output logic [N-1:0]             mul_q,
   input  logic [2*N-1:0]           mul_p,
   output logic                     busy
);
   localparam int unsigned CW = $clog2(run_len(N) + 1);
   localparam logic [CW-1:0] RUN_LEN = CW'(run_len(N));

   seq_state_t     state;
   seq_state_t     state_d;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_d;
   logic [2*N-1:0] head;
   logic [N-1:0]   head_m;
   logic [N-1:0]   head_q;
   logic           fifo_full;
   logic           fifo_empty;
   logic           pop;
   logic           issue;
   logic           cap;
   logic           cap_zero;
   logic           slot_free;
   logic           zero_hit;
   logic           load_r;
   logic [N-1:0]   mul_m_r;
   logic [N-1:0]   mul_q_r;
   logic           out_valid_r;
   logic [2*N-1:0] out_p_r;

   booth_opnd_fifo #(
      .W     (2*N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.in_valid),
      .wr_data ({bus.in_m, bus.in_q}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign head_m       = head[2*N-1:N];
   assign head_q       = head[N-1:0];
   assign bus.in_ready = !fifo_full;
   assign slot_free    = !out_valid_r || bus.out_ready;

`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
   assign zero_hit = (head_m == '0) || (head_q == '0);
`else
   assign zero_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      pop      = 1'b0;
      issue    = 1'b0;
      cap      = 1'b0;
      cap_zero = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (zero_hit) begin
                  state_d = ZERO;
               end else begin
                  issue   = 1'b1;
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            cnt_d   = RUN_LEN;
            state_d = WAIT;
         end
         WAIT: begin
            // Core holds P once its iterations end, so waiting on a full
            // output slot past zero is safe.
            if (cnt != '0) begin
               cnt_d = cnt - CW'(1);
            end else if (slot_free) begin
               cap     = 1'b1;
               state_d = IDLE;
            end
         end
`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
         ZERO: begin
            if (slot_free) begin
               cap      = 1'b1;
               cap_zero = 1'b1;
               state_d  = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         load_r      <= 1'b0;
         mul_m_r     <= '0;
         mul_q_r     <= '0;
         out_valid_r <= 1'b0;
         out_p_r     <= '0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         load_r <= issue;
         if (issue) begin
            mul_m_r <= head_m;
            mul_q_r <= head_q;
         end
         if (cap) begin
            out_p_r     <= cap_zero ? '0 : mul_p;
            out_valid_r <= 1'b1;
         end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign mul_load      = load_r;
   assign mul_m         = mul_m_r;
   assign mul_q         = mul_q_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_p     = out_p_r;
   assign busy          = (state != IDLE) || !fifo_empty;

endmodule
